// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first subtractor: diff = a - b - b_in over WIDTH cycles, start/busy/done handshake.
// Define SERIAL_SUB_OVF_EN to add the registered two's-complement overflow output ovf.
module serial_subtractor #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             b_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
`ifdef SERIAL_SUB_OVF_EN
   output logic             ovf,
`endif
   output logic             b_out
);

   localparam int CW = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_reg, state_next;
   logic [WIDTH-1:0] a_sh_reg, b_sh_reg, res_reg, diff_reg;
   logic [CW-1:0]    cnt_reg;
   logic             br_reg, b_out_reg;
   logic             bit_a, bit_b, d_bit, br_next, last_bit;

   assign bit_a    = a_sh_reg[0];
   assign bit_b    = b_sh_reg[0];
   assign d_bit    = bit_a ^ bit_b ^ br_reg;
   assign br_next  = (~bit_a & bit_b) | (~(bit_a ^ bit_b) & br_reg);
   assign last_bit = (cnt_reg == CW'(WIDTH - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_reg <= IDLE;
      else     state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      busy       = 1'b0;
      done       = 1'b0;
      case (state_reg)
         IDLE: if (start) state_next = RUN;
         RUN: begin
            busy = 1'b1;
            if (last_bit) state_next = DONE;
         end
         DONE: begin
            busy       = 1'b1;
            done       = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Operands shift right so bit i always sits at position 0; result fills from the MSB end.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_sh_reg  <= '0;
         b_sh_reg  <= '0;
         res_reg   <= '0;
         diff_reg  <= '0;
         cnt_reg   <= '0;
         br_reg    <= 1'b0;
         b_out_reg <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (start) begin
                  a_sh_reg <= a;
                  b_sh_reg <= b;
                  br_reg   <= b_in;
                  res_reg  <= '0;
                  cnt_reg  <= '0;
               end
            end
            RUN: begin
               a_sh_reg <= a_sh_reg >> 1;
               b_sh_reg <= b_sh_reg >> 1;
               br_reg   <= br_next;
               res_reg  <= {d_bit, res_reg[WIDTH-1:1]};
               cnt_reg  <= cnt_reg + CW'(1);
               if (last_bit) begin
                  diff_reg  <= {d_bit, res_reg[WIDTH-1:1]};
                  b_out_reg <= br_next;
               end
            end
            default: ;
         endcase
      end
   end

`ifdef SERIAL_SUB_OVF_EN
   logic ovf_reg;

   // On the last bit the operand LSBs are the original MSBs and d_bit is the result MSB.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         ovf_reg <= 1'b0;
      else if (state_reg == RUN && last_bit)
         ovf_reg <= (bit_a ^ bit_b) & (d_bit ^ bit_a);
   end

   assign ovf = ovf_reg;
`endif

   assign diff  = diff_reg;
   assign b_out = b_out_reg;

endmodule
